fft_frame_ctrl: RTL and testbench
=================================

# fft_frame_ctrl

Frame-level sequencer for the FFT soft processor. Collects one frame of 2^FFTSIZ samples from an upstream valid/ready stream, starts the processor with a one-cycle `itr` pulse, serves its `req_in` read strobes from the frame buffer, and pairs the real/imag words the processor emits on `out_en[0]`/`out_en[1]` into a buffered downstream stream. Sits between the sample source/sink and the processor wrapper's `io_in`/`io_out` ports.

## Interface
- `NUBITS`, 32, data word width (matches processor `NUBITS`)
- `FFTSIZ`, 3, log2 of frame length; N = 2^FFTSIZ
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `s_data`  in  NUBITS  input sample
- `s_valid`  in  1  input sample valid
- `s_ready`  out  1  controller accepts sample
- `io_in`  out  NUBITS  word presented to processor `io_in`
- `req_in`  in  1  processor read strobe (one word per asserted cycle)
- `io_out`  in  NUBITS  processor output word
- `out_en`  in  2  processor output strobes: bit0 = real, bit1 = imag
- `itr`  out  1  processor start pulse
- `m_re`, `m_im`  out  NUBITS  output pair
- `m_last`  out  1  pair is last of its frame
- `m_valid`  out  1  output pair valid
- `m_ready`  in  1  downstream accepts pair
- `busy`  out  1  state != LOAD
- `err`  out  3  sticky: [0] underrun, [1] sequence, [2] overflow

## Operation
- FSM states: LOAD, KICK, RUN.
- LOAD: `s_ready`=1; each `s_valid&s_ready` writes buf[wr_ptr], wr_ptr++. On Nth accept -> KICK.
- KICK: `itr`=1 for exactly one cycle; rd_ptr=0, pair_cnt=0 -> RUN.
- RUN: `io_in` is registered and always shows buf[rd_ptr] (0 when rd_ptr==N); `req_in` advances rd_ptr on that edge. `req_in` with rd_ptr==N, or in any state other than RUN: rd_ptr unchanged, `io_in`=0, set err[0].
- `out_en`=01: re_hold<=io_out, re_vld<=1 (a second 01 overwrites re_hold).
- `out_en`=10 with re_vld: push {re_hold, io_out, last=(pair_cnt==N-1)} to output FIFO, re_vld<=0, pair_cnt++. After the Nth push -> LOAD (wr_ptr=0). Downstream drain overlaps the next LOAD.
- `out_en`=10 without re_vld, or `out_en`=11: drop word, set err[1].
- Push with FIFO full: drop pair, set err[2]. pair_cnt still increments (the processor cannot be back-pressured).
- Output FIFO depth N; head drives `m_*`; pop on `m_valid&m_ready`.
- `err` bits clear only on reset.
- `out_en` activity outside RUN: ignored, set err[1].

## Timing
- Reset: state=LOAD, `s_ready`=1, `itr`=0, `io_in`=0, `m_valid`=0, `m_re`/`m_im`=0, `m_last`=0, `busy`=0, `err`=0, all pointers/counters 0, re_vld=0.
- `itr` high in the cycle after the Nth sample handshake; `busy` rises the same cycle.
- `io_in` reflects buf[0] from the first RUN cycle; after a `req_in` edge, the next word is valid the following cycle. Back-to-back `req_in` is supported.
- A pair pushed on edge t gives `m_valid`=1 from cycle t+1 when the FIFO was empty. `m_valid`/data are held stable until `m_ready`.
- Simultaneous push and pop on a full FIFO: the pop frees the slot, so the push succeeds with no err[2].
- Reset mid-frame: buffered samples and FIFO contents are discarded, with no `itr` or `m_valid` glitch.

## Structure
- Shared package: `FFT_N` = 2**FFTSIZ, the state encoding (LOAD/KICK/RUN), and the err bit indices.
- One sub-module `fft_pair_fifo` (synchronous FIFO, width 2*NUBITS+1, depth N, full/empty/push/pop). The frame buffer and FSM stay in the top module.

## Test plan
- Nominal, N=8: feed 1..8 with no stalls -> one `itr` pulse one cycle after sample 8. Processor model reads 8 words = 1..8, emits pairs (k, -k) -> `m_*` yields 8 pairs in order, `m_last` only on pair 8, `err`=0.
- Read overrun: the model issues 9 `req_in` -> 9th `io_in`=0, err=3'b001, remaining behaviour unaffected.
- Sequence errors: `out_en`=10 first, then 11 -> both dropped, err[1]=1, pair_cnt unchanged. A later 01/10 pair is emitted normally.
- Backpressure: `m_ready`=0 across two full frames -> first 8 pairs retained, next 8 dropped, err[2]=1. Releasing `m_ready` gives exactly pairs 1..8 of frame 1.
- Overlap: `m_ready` toggling 50% while the next frame loads -> LOAD accepts samples during drain, and the second `itr` pulse fires after its 8th sample.
- Reset mid-RUN after 3 reads -> all outputs return to reset values. A new 8-sample frame then completes cleanly.

Source files
------------

// File: rtl/fft_frame_ctrl_pkg.sv
// Shared definitions for the FFT frame controller: frame length helper,
// FSM state encoding and sticky error bit positions.
package fft_frame_ctrl_pkg;

    localparam int unsigned FFT_SIZ_DEFAULT = 3;
    localparam int unsigned FFT_N           = 2 ** FFT_SIZ_DEFAULT;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        KICK = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int unsigned ERR_UNDERRUN = 0;
    localparam int unsigned ERR_SEQ      = 1;
    localparam int unsigned ERR_OVF      = 2;

    function automatic int unsigned fft_len(input int unsigned fftsiz);
        return 2 ** fftsiz;
    endfunction

endpackage

// File: rtl/fft_pair_fifo.sv
// Synchronous FIFO holding finished re/im/last pairs; a pop on the same
// edge frees a slot so a push into a full FIFO still succeeds.
module fft_pair_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = count[AW];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero while empty so outputs read as reset values.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame-level sequencer: buffers one frame, kicks the FFT processor, feeds
// its read strobes and pairs its real/imag outputs into a downstream FIFO.
module fft_frame_ctrl
    import fft_frame_ctrl_pkg::*;
#(
    parameter int unsigned NUBITS = 32,
    parameter int unsigned FFTSIZ = FFT_SIZ_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUBITS-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [NUBITS-1:0] io_in,
    input  logic              req_in,
    input  logic [NUBITS-1:0] io_out,
    input  logic [1:0]        out_en,
    output logic              itr,
    output logic [NUBITS-1:0] m_re,
    output logic [NUBITS-1:0] m_im,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic [2:0]        err
);

    localparam int unsigned N     = fft_len(FFTSIZ);
    localparam int unsigned PAIRW = 2 * NUBITS + 1;

    state_t            state;
    state_t            state_nxt;
    logic [NUBITS-1:0] frame_mem [N];
    logic [FFTSIZ-1:0] wr_ptr;
    logic [FFTSIZ:0]   rd_ptr;
    logic [FFTSIZ:0]   rd_nxt;
    logic [FFTSIZ-1:0] pair_cnt;
    logic [NUBITS-1:0] io_in_nxt;
    logic [NUBITS-1:0] re_hold;
    logic              re_vld;
    logic              s_fire;
    logic              rd_at_end;
    logic              rd_adv;
    logic              push;
    logic              pair_last;
    logic [2:0]        err_set;
    logic [PAIRW-1:0]  fifo_wdata;
    logic [PAIRW-1:0]  fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    assign s_ready   = (state == LOAD);
    assign itr       = (state == KICK);
    assign busy      = (state != LOAD);
    assign s_fire    = s_valid && s_ready;
    assign rd_at_end = rd_ptr[FFTSIZ];
    assign rd_adv    = (state == RUN) && req_in && !rd_at_end;
    assign push      = (state == RUN) && (out_en == 2'b10) && re_vld;
    assign pair_last = &pair_cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (s_fire && (&wr_ptr)) state_nxt = KICK;
            KICK:    state_nxt = RUN;
            RUN:     if (push && pair_last) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // io_in is registered from the read pointer that will hold next cycle.
    always_comb begin
        rd_nxt = rd_ptr;
        if (state == KICK) begin
            rd_nxt = '0;
        end else if (rd_adv) begin
            rd_nxt = rd_ptr + 1'b1;
        end
        io_in_nxt = '0;
        if ((state_nxt == RUN) && !rd_nxt[FFTSIZ]) begin
            io_in_nxt = frame_mem[rd_nxt[FFTSIZ-1:0]];
        end
    end

    always_comb begin
        err_set = '0;
        err_set[ERR_UNDERRUN] = req_in && ((state != RUN) || rd_at_end);
        if (state != RUN) begin
            err_set[ERR_SEQ] = (out_en != 2'b00);
        end else begin
            err_set[ERR_SEQ] = (out_en == 2'b11) || ((out_en == 2'b10) && !re_vld);
        end
        err_set[ERR_OVF] = push && fifo_full && !fifo_pop;
    end

    always_ff @(posedge clk) begin
        if (s_fire) begin
            frame_mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= LOAD;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pair_cnt <= '0;
            io_in    <= '0;
            re_hold  <= '0;
            re_vld   <= 1'b0;
            err      <= '0;
        end else begin
            state  <= state_nxt;
            rd_ptr <= rd_nxt;
            io_in  <= io_in_nxt;
            err    <= err | err_set;
            // wr_ptr and pair_cnt wrap to zero on the Nth event of a frame.
            if (s_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (state == KICK) begin
                pair_cnt <= '0;
                re_vld   <= 1'b0;
            end else if (state == RUN) begin
                if (out_en == 2'b01) begin
                    re_hold <= io_out;
                    re_vld  <= 1'b1;
                end else if (push) begin
                    re_vld   <= 1'b0;
                    pair_cnt <= pair_cnt + 1'b1;
                end
            end
        end
    end

    assign fifo_wdata = {re_hold, io_out, pair_last};
    assign fifo_pop   = m_valid && m_ready;
    assign m_valid    = !fifo_empty;
    assign {m_re, m_im, m_last} = fifo_rdata;

    fft_pair_fifo #(
        .WIDTH (PAIRW),
        .AW    (FFTSIZ)
    ) u_pair_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl with a directed processor model.
module tb_fft_frame_ctrl;

    localparam int unsigned W = 32;
    localparam int unsigned N = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  s_data;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  io_in;
    logic          req_in;
    logic [W-1:0]  io_out;
    logic [1:0]    out_en;
    logic          itr;
    logic [W-1:0]  m_re;
    logic [W-1:0]  m_im;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;
    logic          busy;
    logic [2:0]    err;

    int            errors = 0;
    int            checks = 0;
    int            ready_mode = 0;
    logic [2*W:0]  sb [$];

    fft_frame_ctrl #(
        .NUBITS (W),
        .FFTSIZ (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .io_in   (io_in),
        .req_in  (req_in),
        .io_out  (io_out),
        .out_en  (out_en),
        .itr     (itr),
        .m_re    (m_re),
        .m_im    (m_im),
        .m_last  (m_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready pattern: 0 = always ready, 1 = stalled, 2 = toggling.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'b0;
                default: m_ready = ~m_ready;
            endcase
        end
    end

    initial begin
        logic [2*W:0] exp;
        forever begin
            @(negedge clk);
            if (rst && m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pair_unexpected: got %0h expected none", {m_re, m_im, m_last});
                end else begin
                    exp = sb.pop_front();
                    check("pair", {m_re, m_im, m_last}, exp);
                end
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_itr", itr, 1'b0);
        check("rst_io_in", io_in, 0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", {m_re, m_im, m_last}, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 3'b000);
    endtask

    task automatic send_frame(input logic [W-1:0] base);
        for (int i = 0; i < N; i++) begin
            int t = 0;
            s_data  = base + W'(i);
            s_valid = 1'b1;
            while (!s_ready && t < 200) begin
                tick();
                t++;
            end
            if (t >= 200) check("s_ready_timeout", 1'b0, 1'b1);
            tick();
        end
        s_valid = 1'b0;
        // Now one cycle after the Nth handshake: start pulse expected.
        check("itr_pulse", {itr, busy}, 2'b11);
        tick();
        check("itr_single", {itr, busy}, 2'b01);
    endtask

    task automatic read_words(input int n, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) begin
            check("io_in", io_in, (i < N) ? base + W'(i) : '0);
            req_in = 1'b1;
            tick();
        end
        req_in = 1'b0;
    endtask

    task automatic emit_pair(input logic [W-1:0] re, input logic [W-1:0] im,
                             input logic last, input logic expect_push);
        out_en = 2'b01;
        io_out = re;
        tick();
        out_en = 2'b10;
        io_out = im;
        if (expect_push) sb.push_back({re, im, last});
        tick();
        out_en = 2'b00;
        io_out = '0;
    endtask

    task automatic emit_frame(input logic [W-1:0] re_base, input logic [W-1:0] im_base,
                              input logic expect_push);
        for (int k = 1; k <= N; k++) begin
            emit_pair(re_base + W'(k), im_base + W'(k), k == N, expect_push);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 500) begin
            tick();
            t++;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        rst = 1'b0; s_data = '0; s_valid = 1'b0; req_in = 1'b0;
        io_out = '0; out_en = 2'b00;
        #12;
        check_reset_vals();
        @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // Nominal frame: samples 1..8, pairs (k, -k).
        send_frame(1);
        read_words(N, 1);
        check("nom_err_after_read", err, 3'b000);
        for (int k = 1; k <= N; k++) begin
            emit_pair(W'(k), W'(-k), k == N, 1'b1);
        end
        check("nom_back_to_load", {busy, s_ready}, 2'b01);
        wait_drain();
        check("nom_err", err, 3'b000);

        // Read overrun: ninth strobe returns 0 and flags underrun.
        send_frame(32'h10);
        read_words(N + 1, 32'h10);
        check("ovr_io_in_zero", io_in, 0);
        check("ovr_err", err, 3'b001);
        emit_frame(32'd100, 32'd200, 1'b1);
        wait_drain();
        check("ovr_err_after", err, 3'b001);

        // Sequence errors: lone imag, then both strobes; neither counts a pair.
        send_frame(32'h20);
        read_words(N, 32'h20);
        out_en = 2'b10; io_out = 32'hdead;
        tick();
        out_en = 2'b11;
        tick();
        out_en = 2'b00;
        check("seq_err", err, 3'b011);
        check("seq_no_pair", m_valid, 1'b0);
        emit_frame(32'h300, 32'h400, 1'b1);
        check("seq_frame_done", busy, 1'b0);
        wait_drain();

        // Backpressure over two frames: second frame overflows and is lost.
        ready_mode = 1;
        tick();
        send_frame(32'h40);
        read_words(N, 32'h40);
        emit_frame(32'h400, 32'h500, 1'b1);
        check("bp_no_ovf_yet", err, 3'b011);
        send_frame(32'h50);
        read_words(N, 32'h50);
        emit_frame(32'h600, 32'h700, 1'b0);
        check("bp_ovf", err, 3'b111);
        check("bp_head_held", {m_valid, m_re, m_im, m_last}, {1'b1, 32'h401, 32'h501, 1'b0});
        ready_mode = 0;
        wait_drain();
        tick();
        check("bp_empty_after", m_valid, 1'b0);

        // Overlap: next frame loads while the previous one drains at 50%.
        ready_mode = 2;
        send_frame(32'h60);
        read_words(N, 32'h60);
        emit_frame(32'h800, 32'h900, 1'b1);
        send_frame(32'h70);
        read_words(N, 32'h70);
        emit_frame(32'ha00, 32'hb00, 1'b1);
        wait_drain();
        ready_mode = 0;
        tick();

        // Reset mid-RUN after three reads.
        send_frame(32'h90);
        read_words(3, 32'h90);
        rst = 1'b0;
        #2;
        check_reset_vals();
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        check_reset_vals();
        send_frame(32'ha0);
        read_words(N, 32'ha0);
        emit_frame(32'hc00, 32'hd00, 1'b1);
        wait_drain();
        check("final_err", err, 3'b000);
        check("final_idle", {busy, m_valid}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
